// File: rtl/stream_pkt_fifo.sv
// -----------------------------------------------------------------------------
// stream_pkt_fifo
//   Per-output packet buffer that sits directly behind a stream_xbar master
//   port. It absorbs sink backpressure, keeps word order, the source id and
//   packet boundaries intact, and reports how many words and how many
//   complete packets it currently holds.
//
// Parameters
//   T_DATA_WIDTH  payload width in bits
//   T_ID___WIDTH  source-id width (matches the crossbar's m_id width)
//   DEPTH         storage depth in words, power of 2, >= 2
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   s_data_i/s_id_i/s_last_i       write word, id and end-of-packet flag
//   s_valid_i / s_ready_o          write handshake (s_ready_o registered)
//   m_data_o/m_id_o/m_last_o       head word, id and end-of-packet flag
//   m_valid_o / m_ready_i          read handshake (m_valid_o registered)
//   count_o                        words stored
//   pkt_count_o                    complete packets stored (stored words with last=1)
//
// Build option
//   STREAM_PKT_FIFO_SAF_EN  store-and-forward: the head is only presented once
//                           a complete packet is stored, or the FIFO is full
//                           with no complete packet (release mode).
//                           Undefined: cut-through.
// -----------------------------------------------------------------------------
module stream_pkt_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID___WIDTH = 2,
  parameter int DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [T_DATA_WIDTH-1:0]    s_data_i,
  input  logic [T_ID___WIDTH-1:0]    s_id_i,
  input  logic                       s_last_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  output logic [T_DATA_WIDTH-1:0]    m_data_o,
  output logic [T_ID___WIDTH-1:0]    m_id_o,
  output logic                       m_last_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     pkt_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + T_ID___WIDTH + T_DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage entry layout: {last, id, data}
  logic [EW-1:0] mem_q [DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] wr_word_d;
  logic          wr_en;
  logic          rd_en;
  logic          head_last;
`ifdef STREAM_PKT_FIFO_SAF_EN
  logic          release_q, release_d;
`endif

  // Next-state computation for pointers, counters, handshake flags and head.
  always_comb begin
    wr_en     = s_valid_i && s_ready_q;
    rd_en     = m_valid_q && m_ready_i;
    head_last = head_q[EW-1];
    wr_word_d = {s_last_i, s_id_i, s_data_i};

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({wr_en && s_last_i, rd_en && head_last})
      2'b10:   pkt_count_d = pkt_count_q + CW'(1);
      2'b01:   pkt_count_d = pkt_count_q - CW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase

    // A full FIFO stays closed for the cycle of a read; space shows up one
    // edge later, which also removes any path from m_ready_i to s_ready_o.
    s_ready_d = (count_d != DEPTH_C);

    // The head register tracks the entry at the next read pointer. When that
    // entry is being written in this very cycle the RAM does not hold it yet,
    // so it is taken from the write port instead. With nothing stored the
    // head is left untouched so unwritten RAM never reaches the outputs.
    if (count_d == {CW{1'b0}}) begin
      head_d = head_q;
    end else if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wr_word_d;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end

`ifdef STREAM_PKT_FIFO_SAF_EN
    // Release opens the output when the FIFO is full of a single unfinished
    // packet; it closes again once that packet's last word has left.
    if (rd_en && head_last) begin
      release_d = 1'b0;
    end else if ((count_d == DEPTH_C) && (pkt_count_d == {CW{1'b0}})) begin
      release_d = 1'b1;
    end else begin
      release_d = release_q;
    end
    m_valid_d = (count_d != {CW{1'b0}}) &&
                ((pkt_count_d != {CW{1'b0}}) || (count_d == DEPTH_C) || release_d);
`else
    m_valid_d = (count_d != {CW{1'b0}});
`endif
  end

  // Control and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {CW{1'b0}};
      rd_ptr_q    <= {CW{1'b0}};
      count_q     <= {CW{1'b0}};
      pkt_count_q <= {CW{1'b0}};
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      head_q      <= {EW{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      head_q      <= head_d;
    end
  end

`ifdef STREAM_PKT_FIFO_SAF_EN
  // Store-and-forward release flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      release_q <= 1'b0;
    end else begin
      release_q <= release_d;
    end
  end
`endif

  // Storage array write port; contents need no reset because entries are
  // only exposed through the head register after they have been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word_d;
    end
  end

  assign s_ready_o   = s_ready_q;
  assign m_valid_o   = m_valid_q;
  assign m_last_o    = head_q[EW-1];
  assign m_id_o      = head_q[EW-2 -: T_ID___WIDTH];
  assign m_data_o    = head_q[T_DATA_WIDTH-1:0];
  assign count_o     = count_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_pkt_fifo
//   Self-checking bench for stream_pkt_fifo. A queue-based reference model of
//   the buffer supplies every expected value; directed sequences cover the
//   listed scenarios, followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_stream_pkt_fifo;

  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data_i;
  logic [IW-1:0] s_id_i;
  logic          s_last_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic [IW-1:0] m_id_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [CW-1:0] count_o;
  logic [CW-1:0] pkt_count_o;

  stream_pkt_fifo #(.T_DATA_WIDTH(DW), .T_ID___WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_id_i(s_id_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .count_o(count_o), .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: stored words as {last, id, data}
  logic [DW+IW:0] q[$];
  logic [DW+IW:0] popped[$];
  bit  ready_block;
  bit  rel_m;
  bit  last_wr_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int lasts_stored();
    int n = 0;
    foreach (q[i]) if (q[i][DW+IW]) n++;
    return n;
  endfunction

  function automatic bit exp_valid();
`ifdef STREAM_PKT_FIFO_SAF_EN
    return (q.size() != 0) && (lasts_stored() != 0 || q.size() == DEPTH || rel_m);
`else
    return q.size() != 0;
`endif
  endfunction

  function automatic bit exp_ready();
    return !ready_block && (q.size() != DEPTH);
  endfunction

  // One clock cycle: entered and left at a falling edge.
  task automatic cycle(input bit sv, input logic [DW-1:0] d, input logic [IW-1:0] id,
                       input bit l, input bit mr, input bit r);
    bit wr, rd;
    logic [DW+IW:0] w;
    s_valid_i = sv; s_data_i = d; s_id_i = id; s_last_i = l;
    m_ready_i = mr; rst = r;
    #1;
    check_eq("count", 32'(count_o), 32'(q.size()));
    check_eq("pkt_count", 32'(pkt_count_o), 32'(lasts_stored()));
    check_eq("s_ready", 32'(s_ready_o), 32'(exp_ready()));
    check_eq("m_valid", 32'(m_valid_o), 32'(exp_valid()));
    if (exp_valid()) check_eq("head", 32'({m_last_o, m_id_o, m_data_o}), 32'(q[0]));
    wr = sv && exp_ready();
    rd = mr && exp_valid();
    @(posedge clk);
    if (r) begin
      q.delete();
      ready_block = 1'b1;
      rel_m       = 1'b0;
      last_wr_acc = 1'b0;
    end else begin
      if (rd) begin
        w = q.pop_front();
        popped.push_back(w);
        if (w[DW+IW]) rel_m = 1'b0;
      end
      if (wr) q.push_back({l, id, d});
      if (q.size() == DEPTH && lasts_stored() == 0) rel_m = 1'b1;
      ready_block = 1'b0;
      last_wr_acc = wr;
    end
    @(negedge clk);
  endtask

  // Present one word until accepted, bounded.
  task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id, input bit l, input bit mr);
    int n = 0;
    do begin
      cycle(1'b1, d, id, l, mr, 1'b0);
      n++;
    end while (!last_wr_acc && n < 40);
    if (!last_wr_acc) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 2'd0, 1'b0, mr, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int idx, n;
    bit tog, pend, sv, pl, mr, r;
    logic [DW-1:0] pd;
    logic [IW-1:0] pid;

    rst = 1'b1; s_valid_i = 1'b0; s_data_i = 8'h00; s_id_i = 2'd0;
    s_last_i = 1'b0; m_ready_i = 1'b0;
    ready_block = 1'b1; rel_m = 1'b0; last_wr_acc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data", 32'(m_data_o), 32'd0);
    check_eq("rst_last", 32'(m_last_o), 32'd0);

    // 1: three-word packet held at the head
    send(8'h11, 2'd1, 1'b0, 1'b0);
    send(8'h22, 2'd1, 1'b0, 1'b0);
    send(8'h33, 2'd1, 1'b1, 1'b0);
    idle(3, 1'b0);
    check_eq("t1_count", 32'(count_o), 32'd3);
    check_eq("t1_pkt", 32'(pkt_count_o), 32'd1);
    check_eq("t1_data", 32'(m_data_o), 32'h11);
    check_eq("t1_id", 32'(m_id_o), 32'd1);
    idle(4, 1'b1);

    // 2: fill, then a single read
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i), 2'(i), (i == 3), 1'b0);
    idle(1, 1'b0);
    check_eq("t2_full_count", 32'(count_o), 32'd8);
    check_eq("t2_full_ready", 32'(s_ready_o), 32'd0);
    cycle(1'b1, 8'h99, 2'd0, 1'b0, 1'b1, 1'b0);   // read while full: write refused
    check_eq("t2_count7", 32'(count_o), 32'd7);
    check_eq("t2_ready", 32'(s_ready_o), 32'd1);
    idle(10, 1'b1);

    // 3: 20-word stream with toggling sink
    do_reset();
    popped.delete();
    idx = 0; tog = 1'b0; n = 0;
    while ((idx < 20 || q.size() != 0) && n < 200) begin
      tog = !tog;
      cycle(idx < 20, 8'(idx), 2'd2, (idx % 4 == 3), tog, 1'b0);
      if (last_wr_acc) idx++;
      n++;
    end
    check_eq("t3_nwords", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20 && i < popped.size(); i++) begin
      check_eq("t3_order", 32'(popped[i][DW-1:0]), 32'(i));
      check_eq("t3_last", 32'(popped[i][DW+IW]), 32'(i % 4 == 3));
    end

    // 4: simultaneous read/write at count 4
    do_reset();
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 2'd3, (i == 1), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'(8'h70 + i), 2'd3, (i == 1 || i == 3), 1'b1, 1'b0);
      check_eq("t4_count", 32'(count_o), 32'd4);
    end
    idle(8, 1'b1);

    // 5: reset mid-packet
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h80 + i), 2'd0, 1'b0, 1'b0);
    check_eq("t5_count5", 32'(count_o), 32'd5);
    cycle(1'b1, 8'h85, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("t5_count", 32'(count_o), 32'd0);
    check_eq("t5_pkt", 32'(pkt_count_o), 32'd0);
    check_eq("t5_valid", 32'(m_valid_o), 32'd0);
    check_eq("t5_ready0", 32'(s_ready_o), 32'd0);
    check_eq("t5_data", 32'(m_data_o), 32'd0);
    idle(1, 1'b0);
    check_eq("t5_ready1", 32'(s_ready_o), 32'd1);

`ifdef STREAM_PKT_FIFO_SAF_EN
    // 6: store-and-forward gating and release
    do_reset();
    for (int i = 0; i < 3; i++) send(8'(8'hA0 + i), 2'd1, 1'b0, 1'b1);
    idle(2, 1'b1);
    check_eq("t6_gated", 32'(m_valid_o), 32'd0);
    send(8'hA3, 2'd1, 1'b1, 1'b1);
    check_eq("t6_open", 32'(m_valid_o), 32'd1);
    idle(6, 1'b1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'(8'hB0 + i), 2'd2, 1'b0, 1'b0);
    check_eq("t6_release", 32'(m_valid_o), 32'd1);
    idle(3, 1'b1);
    send(8'hB8, 2'd2, 1'b1, 1'b1);
    idle(10, 1'b1);
`endif

    // Random traffic with upstream holding refused words
    do_reset();
    pend = 1'b0; sv = 1'b0; pd = 8'h00; pid = 2'd0; pl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        sv  = ($urandom_range(0, 3) != 0);
        pd  = 8'($urandom);
        pid = 2'($urandom);
        pl  = ($urandom_range(0, 3) == 0);
      end
      mr = ($urandom_range(0, 2) != 0) || (i % 97 > 80);
      if (i % 97 < 15) mr = 1'b0;
      r  = ($urandom_range(0, 149) == 0);
      cycle(sv, pd, pid, pl, mr, r);
      pend = sv && !last_wr_acc && !r;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_pkt_fifo.md
Name: stream_pkt_fifo

Overview:
Per-output packet buffer placed directly downstream of each stream_xbar master port.
- Accepts the crossbar's m_data/m_id/m_last/m_valid stream and drives back m_ready.
- Decouples the crossbar from sink backpressure.
- Preserves word order, id and packet boundaries.
- Reports fill level and the number of complete packets held.

Parameters:
T_DATA_WIDTH, 8, payload width in bits
T_ID___WIDTH, 2, source-id width; must match the crossbar's m_id width
DEPTH, 8, storage depth in words; power of 2, minimum 2

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
s_data_i  input  T_DATA_WIDTH  write payload (from crossbar m_data_o)
s_id_i  input  T_ID___WIDTH  source id (from crossbar m_id_o)
s_last_i  input  1  last word of packet
s_valid_i  input  1  write request
s_ready_o  output  1  FIFO can accept a word
m_data_o  output  T_DATA_WIDTH  head payload
m_id_o  output  T_ID___WIDTH  head id
m_last_o  output  1  head is last word of its packet
m_valid_o  output  1  head word available
m_ready_i  input  1  sink accepts head
count_o  output  $clog2(DEPTH)+1  words stored
pkt_count_o  output  $clog2(DEPTH)+1  complete packets stored (words with last=1)

Behaviour:
- Storage: circular RAM of {last, id, data}, DEPTH entries.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Both wrap from DEPTH-1 to 0 in the address bits.
- Handshake: write when s_valid_i && s_ready_o; read when m_valid_o && m_ready_i.
- Stability: s_data_i, s_id_i and s_last_i are sampled only on a write. m_data_o, m_id_o and m_last_o stay stable while m_valid_o=1 and m_ready_i=0.
- s_ready_o: equals (count_o != DEPTH), registered. A full FIFO accepts no write, even in a cycle where a read also occurs; s_ready_o rises the cycle after the read.
- Latency: a word written at edge N is presented with m_valid_o=1 after edge N. There is no combinational path from s_valid_i to m_valid_o, nor from m_ready_i to s_ready_o.
- count_o: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_count_o: +1 on a write with s_last_i=1, -1 on a read with m_last_o=1; both in the same cycle leaves it unchanged.
- Empty: m_valid_o=0. m_data_o, m_id_o and m_last_o are don't-care but must not be X after reset (RAM output register reset to 0).
- Reset (rst=1 at an edge): pointers, count_o and pkt_count_o go to 0; m_valid_o=0, m_last_o=0, s_ready_o=0. On the first edge with rst=0, s_ready_o becomes 1.
- Reset mid-packet: all stored words are discarded, including partial packets; no recovery of in-flight data.
- No overflow or underflow is possible by construction. A write attempted while s_ready_o=0 is ignored and the upstream holds the word.

Optional Feature:
Macro: STREAM_PKT_FIFO_SAF_EN (store-and-forward).
- Defined:
  - m_valid_o is gated by (pkt_count_o != 0 || count_o == DEPTH || release).
  - A packet is presented only once its last word is stored.
  - Deadlock guard: if the FIFO fills with no complete packet, a release flag sets. Release keeps output open until a word with last=1 is read, then clears.
  - Gating adds no extra latency beyond the last-word write: m_valid_o rises the cycle after the last word is written.
- Undefined: cut-through. m_valid_o = (count_o != 0); pkt_count_o is still maintained.

Test Plan:
1. Reset, then write 3 words 0x11, 0x22, 0x33 (id=1, last on 0x33) with m_ready_i=0 -> count_o=3, pkt_count_o=1, m_data_o=0x11, m_id_o=1 held stable; s_ready_o=1.
2. Write 8 words with m_ready_i=0 -> s_ready_o=0 after the 8th write, count_o=8. Next, m_ready_i=1 for one cycle -> 0x first word read, count_o=7, s_ready_o=1 the following cycle.
3. Continuous stream of 20 words (0x00..0x13, last every 4th) with m_ready_i toggling 1/0 each cycle -> output order 0x00..0x13 exact, m_last_o on 0x03/0x07/0x0B/0x0F/0x13, pointers wrap with no loss.
4. Simultaneous write and read at count_o=4 for 6 cycles -> count_o stays 4; pkt_count_o unchanged when the last bits written and read coincide.
5. Assert rst for 1 cycle mid-packet with count_o=5 -> next cycle count_o=0, pkt_count_o=0, m_valid_o=0, s_ready_o=0, then 1.
6. With STREAM_PKT_FIFO_SAF_EN defined, write 3 words without last -> m_valid_o=0. Write the 4th with last -> m_valid_o=1 next cycle. Separately, write 8 words with no last -> release sets and m_valid_o=1.
